// File: rtl/vec_alu_arbiter.sv
// Round-robin front end sharing one combinational vector ALU between two requesters,
// holding operands for a fixed execute window and returning results over a backpressured channel.
module vec_alu_arbiter #(
    parameter int unsigned LANES       = 16,
    parameter int unsigned LANE_W      = 16,
    parameter int unsigned FLAG_W      = 4,
    parameter int unsigned ALU_LATENCY = 1,
    localparam int unsigned VW = LANES * LANE_W,
    localparam int unsigned FW = LANES * FLAG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [VW-1:0] req0_a,
    input  logic [VW-1:0] req0_b,
    input  logic [2:0]    req0_opcode,
    input  logic          req0_flag_scalar,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [VW-1:0] req1_a,
    input  logic [VW-1:0] req1_b,
    input  logic [2:0]    req1_opcode,
    input  logic          req1_flag_scalar,
    output logic [VW-1:0] alu_a,
    output logic [VW-1:0] alu_b,
    output logic [2:0]    alu_opcode,
    output logic          alu_flag_scalar,
    input  logic [VW-1:0] alu_result,
    input  logic [FW-1:0] alu_flags,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [VW-1:0] rsp_result,
    output logic [FW-1:0] rsp_flags
);

    localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       capture;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // A lone requester wins outright; a tie goes to whoever did not win last.
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (count == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            last_grant      <= 1'b1;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_opcode      <= '0;
            alu_flag_scalar <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_id          <= 1'b0;
            rsp_result      <= '0;
            rsp_flags       <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                alu_a           <= grant ? req1_a : req0_a;
                alu_b           <= grant ? req1_b : req0_b;
                alu_opcode      <= grant ? req1_opcode : req0_opcode;
                alu_flag_scalar <= grant ? req1_flag_scalar : req0_flag_scalar;
                rsp_id          <= grant;
                last_grant      <= grant;
                count           <= CNT_LOAD;
            end
            if (state == EXEC && count != '0) begin
                count <= count - 4'd1;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                rsp_valid  <= 1'b1;
            end
            if (state == RESP && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vec_alu_arbiter.md
Name: vec_alu_arbiter

Overview:
- Shares one 16-lane x 16-bit vector ALU between two requesters, e.g. the vector execute stage and the scalar-broadcast path.
- Round-robin arbitration with a valid/ready accept handshake.
- Registers the winner's operands and holds them on the ALU inputs for a fixed execute window.
- Captures result and per-lane flags, then returns them on a response channel that supports backpressure.
- Sits between the issue logic and the vector ALU, whose inputs and outputs are combinational.

Parameters:
- LANES, 16, number of vector lanes.
- LANE_W, 16, bits per lane. Vector width VW = LANES*LANE_W (256).
- FLAG_W, 4, flag bits per lane. Flag width FW = LANES*FLAG_W (64).
- ALU_LATENCY, 1, cycles the operands are held on the ALU before capture. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  VW  requester 0 operand vectors.
- req0_opcode  in  3  requester 0 ALU opcode.
- req0_flag_scalar  in  1  requester 0 scalar-mode flag.
- req1_valid, req1_ready, req1_a, req1_b, req1_opcode, req1_flag_scalar  same as requester 0, for requester 1.
- alu_a, alu_b  out  VW  registered operands driven to the ALU.
- alu_opcode  out  3  registered opcode driven to the ALU.
- alu_flag_scalar  out  1  registered scalar flag driven to the ALU.
- alu_result  in  VW  ALU result, combinational from the alu_* outputs.
- alu_flags  in  FW  ALU per-lane flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  VW  captured result.
- rsp_flags  out  FW  captured flags.

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - all alu_* and rsp_* registers = 0;
  - rsp_valid = 0;
  - exec counter = 0;
  - last_grant = 1, so req0 wins the first tie.
- Ready generation: reqN_ready = (state==IDLE) && grant==N, combinational from the valids. At most one ready is high per cycle; both readys are 0 outside IDLE.
- Arbitration in IDLE:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: stay in IDLE; registers hold.
- Accept: on the cycle valid && ready, latch that requester's a, b, opcode and flag_scalar into the alu_* registers. Also latch rsp_id = grant, set last_grant = grant, load the counter with ALU_LATENCY-1, and go to EXEC.
- EXEC:
  - alu_* stay stable.
  - Counter > 0: decrement it.
  - Counter == 0: capture alu_result into rsp_result and alu_flags into rsp_flags, set rsp_valid = 1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_flags hold until rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE. No new accept happens in this same cycle; the next accept is possible one cycle later.
- Latency: accept at cycle T gives rsp_valid at T+1+ALU_LATENCY. Best-case throughput is one operation per ALU_LATENCY+2 cycles.
- alu_* registers keep their last value outside EXEC; they are never zeroed except by reset.
- Requests arriving outside IDLE are not accepted. Requesters must hold valid and payload until ready.
- rsp_ready while rsp_valid = 0 is ignored.
- Reset asserted in any state (including mid-EXEC or RESP with a pending response): the next edge returns to IDLE with reset values. The in-flight operation is dropped and rsp_valid is not asserted for it.
- Operand width is opaque to this block; no arithmetic is performed here.

Test Plan:
- Single op: req0 ADD, a lanes = 0x0003, b lanes = 0x0004, rsp_ready = 1 -> req0_ready high 1 cycle; rsp_valid 2 cycles after accept with rsp_id = 0 and rsp_result = the ALU model output; back in IDLE the following cycle.
- Tie alternation: req0 and req1 valid continuously for 4 ops -> grants in order 0,1,0,1; each rsp_id matches its grant.
- Backpressure: rsp_ready = 0 for 3 cycles after rsp_valid -> rsp_result, rsp_flags and rsp_id stable; readys stay 0; a queued req1 is accepted only in the IDLE cycle after the handshake.
- Busy rejection: req1 asserts valid while in EXEC -> req1_ready = 0 until IDLE; payload is then accepted unchanged.
- ALU_LATENCY = 3: accept at cycle 10 -> alu_* stable for cycles 11-13; capture at 13; rsp_valid at cycle 14.
- Reset mid-operation: rst pulsed during EXEC or during RESP with rsp_valid = 1 -> next cycle rsp_valid = 0 and all outputs zeroed; the first following tie grants req0.
